// File: rtl/spi_fsm.sv
// SPI slave transaction sequencer: address phase, then a read or write data phase.
// Outputs are Moore-decoded from the state register only.
module spi_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       sclk_posedge,
  input  logic       sclk_negedge,
  input  logic       rw_bit,
  output logic [1:0] sr_mode,
  output logic       addr_we,
  output logic       dm_we,
  output logic       miso_buff_en,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    LATCH_ADDR  = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SHIFT  = 3'd4,
    WRITE_GET   = 3'd5,
    WRITE_STORE = 3'd6,
    DONE        = 3'd7
  } state_t;

  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_LEFT  = 2'b01;
  localparam logic [1:0] SR_PLOAD = 2'b11;
  localparam logic [3:0] LAST_BIT = 4'd7;

  state_t     state_r, next_state_s;
  logic [3:0] cnt_r, cnt_nxt_s;
  logic       armed_r;

  // State, bit counter and start-arming register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      armed_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_nxt_s;
      // a transaction may start only after cs_n has been seen high since reset
      armed_r <= cs_n ? 1'b1 : armed_r;
    end
  end

  // Next state and counter; cs_n high aborts ahead of any sclk pulse
  always_comb begin
    next_state_s = state_r;
    cnt_nxt_s    = cnt_r;
    if (state_r != IDLE && cs_n) begin
      next_state_s = IDLE;
      cnt_nxt_s    = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_nxt_s = 4'd0;
          if (!cs_n && armed_r) begin
            next_state_s = GET_ADDR;
          end else begin
            next_state_s = IDLE;
          end
        end
        GET_ADDR, WRITE_GET: begin
          if (sclk_posedge) begin
            if (cnt_r == LAST_BIT) begin
              next_state_s = (state_r == GET_ADDR) ? LATCH_ADDR : WRITE_STORE;
              cnt_nxt_s    = 4'd0;
            end else begin
              cnt_nxt_s = cnt_r + 4'd1;
            end
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        LATCH_ADDR: begin
          next_state_s = rw_bit ? READ_LOAD : WRITE_GET;
          cnt_nxt_s    = 4'd0;
        end
        READ_LOAD: begin
          next_state_s = READ_SHIFT;
          cnt_nxt_s    = 4'd0;
        end
        READ_SHIFT: begin
          if (sclk_negedge) begin
            if (cnt_r == LAST_BIT) begin
              next_state_s = DONE;
              cnt_nxt_s    = 4'd0;
            end else begin
              cnt_nxt_s = cnt_r + 4'd1;
            end
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        WRITE_STORE: begin
          next_state_s = DONE;
          cnt_nxt_s    = 4'd0;
        end
        DONE: begin
          next_state_s = DONE;
          cnt_nxt_s    = 4'd0;
        end
        default: begin
          next_state_s = IDLE;
          cnt_nxt_s    = 4'd0;
        end
      endcase
    end
  end

  // Output decode from the state register
  always_comb begin
    sr_mode      = SR_HOLD;
    addr_we      = 1'b0;
    dm_we        = 1'b0;
    miso_buff_en = 1'b0;
    busy         = (state_r != IDLE);
    case (state_r)
      GET_ADDR, WRITE_GET: sr_mode = SR_LEFT;
      LATCH_ADDR:          addr_we = 1'b1;
      READ_LOAD: begin
        sr_mode      = SR_PLOAD;
        miso_buff_en = 1'b1;
      end
      READ_SHIFT: begin
        sr_mode      = SR_LEFT;
        miso_buff_en = 1'b1;
      end
      WRITE_STORE:         dm_we = 1'b1;
      default:             sr_mode = SR_HOLD;
    endcase
  end

endmodule

// File: tb/tb_spi_fsm.sv
// Directed self-checking bench for spi_fsm: write, read, abort, simultaneous
// events, mid-operation reset and ignored edges.
module tb_spi_fsm;

  logic       clk = 1'b0;
  logic       reset, cs_n, sclk_posedge, sclk_negedge, rw_bit;
  logic [1:0] sr_mode;
  logic       addr_we, dm_we, miso_buff_en, busy;

  int total = 0;
  int passed = 0;
  int addr_cnt = 0, dm_cnt = 0, miso_cnt = 0, both_cnt = 0;
  int a0, d0, m0;

  localparam logic [2:0] S_IDLE = 3'd0, S_GET_ADDR = 3'd1, S_LATCH = 3'd2,
                         S_READ_SHIFT = 3'd4, S_WRITE_GET = 3'd5, S_DONE = 3'd7;

  spi_fsm dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .sclk_posedge(sclk_posedge),
    .sclk_negedge(sclk_negedge), .rw_bit(rw_bit), .sr_mode(sr_mode),
    .addr_we(addr_we), .dm_we(dm_we), .miso_buff_en(miso_buff_en), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse-count monitor sampled away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      addr_cnt <= addr_cnt + (addr_we ? 1 : 0);
      dm_cnt   <= dm_cnt + (dm_we ? 1 : 0);
      miso_cnt <= miso_cnt + (miso_buff_en ? 1 : 0);
      both_cnt <= both_cnt + ((addr_we && dm_we) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pos_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sclk_posedge = 1'b1; tick(); sclk_posedge = 1'b0;
    end
  endtask

  task automatic neg_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sclk_negedge = 1'b1; tick(); sclk_negedge = 1'b0;
    end
  endtask

  task automatic snap();
    tick();
    a0 = addr_cnt; d0 = dm_cnt; m0 = miso_cnt;
  endtask

  task automatic test_reset();
    reset = 1'b1; cs_n = 1'b0; sclk_posedge = 1'b0; sclk_negedge = 1'b0; rw_bit = 1'b0;
    tick(); tick();
    total++;
    if ({sr_mode, addr_we, dm_we, miso_buff_en, busy} !== 6'b000000)
      $display("FAIL reset_outputs got=%b exp=000000", {sr_mode, addr_we, dm_we, miso_buff_en, busy});
    else passed++;
    reset = 1'b0;
    tick(); tick();
    total++;
    if (busy !== 1'b0) $display("FAIL reset_needs_fresh_cs busy=%b exp=0", busy);
    else passed++;
    cs_n = 1'b1; tick();
  endtask

  task automatic test_write();
    snap();
    cs_n = 1'b0; rw_bit = 1'b0; tick();
    total++;
    if (busy !== 1'b1 || sr_mode !== 2'b01)
      $display("FAIL wr_get_addr busy=%b sr_mode=%b exp busy=1 sr_mode=01", busy, sr_mode);
    else passed++;
    pos_pulses(8);
    total++;
    if (addr_we !== 1'b1 || sr_mode !== 2'b00)
      $display("FAIL wr_latch addr_we=%b sr_mode=%b exp 1/00", addr_we, sr_mode);
    else passed++;
    tick();
    total++;
    if (addr_we !== 1'b0 || sr_mode !== 2'b01 || dut.state_r !== S_WRITE_GET)
      $display("FAIL wr_write_get addr_we=%b sr_mode=%b state=%0d exp 0/01/5", addr_we, sr_mode, dut.state_r);
    else passed++;
    pos_pulses(7);
    total++;
    if (dm_we !== 1'b0) $display("FAIL wr_early_dm dm_we=%b exp=0", dm_we);
    else passed++;
    pos_pulses(1);
    total++;
    if (dm_we !== 1'b1 || miso_buff_en !== 1'b0)
      $display("FAIL wr_store dm_we=%b miso=%b exp 1/0", dm_we, miso_buff_en);
    else passed++;
    tick();
    total++;
    if (dm_we !== 1'b0 || busy !== 1'b1 || dut.state_r !== S_DONE)
      $display("FAIL wr_done dm_we=%b busy=%b state=%0d exp 0/1/7", dm_we, busy, dut.state_r);
    else passed++;
    cs_n = 1'b1; tick(); tick();
    total++;
    if (busy !== 1'b0) $display("FAIL wr_idle busy=%b exp=0", busy);
    else passed++;
    total++;
    if (addr_cnt - a0 != 1 || dm_cnt - d0 != 1 || miso_cnt != m0 || both_cnt != 0)
      $display("FAIL wr_pulse_counts addr=%0d dm=%0d miso=%0d both=%0d exp 1/1/0/0",
               addr_cnt - a0, dm_cnt - d0, miso_cnt - m0, both_cnt);
    else passed++;
  endtask

  task automatic test_read();
    snap();
    cs_n = 1'b0; rw_bit = 1'b1; tick();
    pos_pulses(3);
    sclk_posedge = 1'b1; sclk_negedge = 1'b1; tick();
    sclk_posedge = 1'b0; sclk_negedge = 1'b0;
    total++;
    if (dut.cnt_r !== 4'd4) $display("FAIL rd_simul_edges cnt=%0d exp=4", dut.cnt_r);
    else passed++;
    pos_pulses(4);
    total++;
    if (addr_we !== 1'b1) $display("FAIL rd_latch addr_we=%b exp=1", addr_we);
    else passed++;
    tick();
    total++;
    if (sr_mode !== 2'b11 || miso_buff_en !== 1'b1)
      $display("FAIL rd_pload sr_mode=%b miso=%b exp 11/1", sr_mode, miso_buff_en);
    else passed++;
    tick();
    total++;
    if (sr_mode !== 2'b01 || miso_buff_en !== 1'b1 || dut.state_r !== S_READ_SHIFT)
      $display("FAIL rd_shift sr_mode=%b miso=%b state=%0d exp 01/1/4", sr_mode, miso_buff_en, dut.state_r);
    else passed++;
    neg_pulses(7);
    total++;
    if (dut.state_r !== S_READ_SHIFT || miso_buff_en !== 1'b1)
      $display("FAIL rd_before_last state=%0d miso=%b exp 4/1", dut.state_r, miso_buff_en);
    else passed++;
    neg_pulses(1);
    total++;
    if (dut.state_r !== S_DONE || miso_buff_en !== 1'b0 || busy !== 1'b1)
      $display("FAIL rd_done state=%0d miso=%b busy=%b exp 7/0/1", dut.state_r, miso_buff_en, busy);
    else passed++;
    cs_n = 1'b1; tick(); tick();
    total++;
    if (addr_cnt - a0 != 1 || dm_cnt != d0 || miso_cnt - m0 < 9)
      $display("FAIL rd_pulse_counts addr=%0d dm=%0d miso=%0d exp 1/0/>=9",
               addr_cnt - a0, dm_cnt - d0, miso_cnt - m0);
    else passed++;
  endtask

  task automatic test_ignored_edges();
    cs_n = 1'b0; rw_bit = 1'b1; tick();
    pos_pulses(2);
    neg_pulses(3);
    total++;
    if (dut.cnt_r !== 4'd2 || dut.state_r !== S_GET_ADDR)
      $display("FAIL ign_neg_in_addr cnt=%0d state=%0d exp 2/1", dut.cnt_r, dut.state_r);
    else passed++;
    pos_pulses(6); tick(); tick();
    neg_pulses(2);
    pos_pulses(3);
    total++;
    if (dut.cnt_r !== 4'd2 || dut.state_r !== S_READ_SHIFT)
      $display("FAIL ign_pos_in_shift cnt=%0d state=%0d exp 2/4", dut.cnt_r, dut.state_r);
    else passed++;
    cs_n = 1'b1; tick(); tick();
  endtask

  task automatic test_abort();
    snap();
    cs_n = 1'b0; rw_bit = 1'b0; tick();
    pos_pulses(5);
    cs_n = 1'b1; tick();
    total++;
    if (busy !== 1'b0 || dut.state_r !== S_IDLE || dut.cnt_r !== 4'd0)
      $display("FAIL abort_idle busy=%b state=%0d cnt=%0d exp 0/0/0", busy, dut.state_r, dut.cnt_r);
    else passed++;
    tick(); tick();
    total++;
    if (addr_cnt != a0 || dm_cnt != d0)
      $display("FAIL abort_no_we addr=%0d dm=%0d exp 0/0", addr_cnt - a0, dm_cnt - d0);
    else passed++;
  endtask

  task automatic test_simultaneous();
    snap();
    cs_n = 1'b0; rw_bit = 1'b0; tick();
    pos_pulses(8); tick();
    pos_pulses(7);
    cs_n = 1'b1; sclk_posedge = 1'b1; tick(); sclk_posedge = 1'b0;
    total++;
    if (busy !== 1'b0 || dm_we !== 1'b0)
      $display("FAIL simul_abort busy=%b dm_we=%b exp 0/0", busy, dm_we);
    else passed++;
    tick(); tick();
    total++;
    if (dm_cnt != d0 || addr_cnt - a0 != 1)
      $display("FAIL simul_counts dm=%0d addr=%0d exp 0/1", dm_cnt - d0, addr_cnt - a0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    cs_n = 1'b0; rw_bit = 1'b1; tick();
    pos_pulses(8); tick(); tick();
    neg_pulses(3);
    total++;
    if (dut.cnt_r !== 4'd3 || miso_buff_en !== 1'b1)
      $display("FAIL rst_mid_pre cnt=%0d miso=%b exp 3/1", dut.cnt_r, miso_buff_en);
    else passed++;
    reset = 1'b1; tick(); reset = 1'b0;
    total++;
    if (sr_mode !== 2'b00 || miso_buff_en !== 1'b0 || busy !== 1'b0 || dut.cnt_r !== 4'd0)
      $display("FAIL rst_mid sr_mode=%b miso=%b busy=%b cnt=%0d exp 00/0/0/0",
               sr_mode, miso_buff_en, busy, dut.cnt_r);
    else passed++;
    tick(); tick();
    total++;
    if (busy !== 1'b0) $display("FAIL rst_mid_no_restart busy=%b exp=0", busy);
    else passed++;
    cs_n = 1'b1; tick(); cs_n = 1'b0; tick();
    total++;
    if (busy !== 1'b1 || dut.state_r !== S_GET_ADDR)
      $display("FAIL rst_mid_restart busy=%b state=%0d exp 1/1", busy, dut.state_r);
    else passed++;
    cs_n = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignored_edges();
    test_abort();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
